remote_comm: RTL and testbench
==============================

REMOTE_COMM -- requirements
Module: remote_comm

Interface
REQ-001 Parameter BAUD_DIV, default 2604, clocks per UART bit (19200 baud at 50 MHz); SHALL accept any value >= 4.
REQ-002 clk  input  1  sole clock; all state updates on rising edge.
REQ-003 rst_n  input  1  reset; synchronous and active-high (asserted = 1 despite the name).
REQ-004 RX  input  1  UART serial in from the robot; idle high; asynchronous to clk.
REQ-005 TX  output  1  UART serial out to the robot; idle high.
REQ-006 cmd  input  16  command word to transmit.
REQ-007 send_cmd  input  1  one-cycle strobe requesting transmission of cmd.
REQ-008 cmd_sent  output  1  level; high once both command bytes are fully transmitted.
REQ-009 resp_rdy  output  1  level; high while resp holds a newly received byte.
REQ-010 resp  output  8  last byte received on RX.

Function
REQ-011 UART framing SHALL be 8N1: start bit 0, 8 data bits LSB first, stop bit 1; every bit lasts exactly BAUD_DIV clocks.
REQ-012 On send_cmd while idle, cmd SHALL be latched that cycle; later cmd changes SHALL not affect the transfer.
REQ-013 Byte order SHALL be cmd[15:8] first, then cmd[7:0]; the second start bit SHALL begin the cycle after the first stop bit ends (no idle gap).
REQ-014 TX start bit of the high byte SHALL begin on the cycle after send_cmd is sampled (latency 1 clock).
REQ-015 Command FSM states: IDLE -> HIGH (sending high byte) -> LOW (sending low byte) -> IDLE; HIGH->LOW on high-byte stop completion; LOW->IDLE on low-byte stop completion.
REQ-016 cmd_sent SHALL clear on the cycle send_cmd is accepted and SHALL set the cycle after the low-byte stop bit completes (20*BAUD_DIV clocks after transmission start); it SHALL stay high until the next accepted send_cmd.
REQ-017 send_cmd asserted while not IDLE SHALL be ignored; the transfer in progress SHALL be unaffected.
REQ-018 RX SHALL pass through a two-flop synchronizer, reset to 1, before any use.
REQ-019 Receiver SHALL detect a start bit on a synchronized 1->0 transition while idle, then sample each bit at its mid-point (BAUD_DIV/2 clocks after the start edge, then every BAUD_DIV clocks).
REQ-020 If the start bit mid-point sample is 1, the receiver SHALL abort to idle without changing resp or resp_rdy (glitch rejection).
REQ-021 After the 8th data bit, the receiver SHALL sample the stop bit at its mid-point and then, in the same cycle, load resp and set resp_rdy; a 0 stop bit SHALL still load resp (no framing-error output).
REQ-022 resp_rdy SHALL clear when the next start bit is detected or when send_cmd is accepted, whichever comes first; resp SHALL hold its value until the next byte completes.
REQ-023 Transmitter and receiver SHALL operate independently; full duplex operation SHALL not corrupt either direction.
REQ-024 Baud counters SHALL be wide enough for BAUD_DIV and SHALL reload, not wrap, at bit boundaries.

Reset
REQ-025 While rst_n = 1: TX = 1, cmd_sent = 0, resp_rdy = 0, resp = 8'h00, both FSMs idle, counters 0, synchronizer flops 1.
REQ-026 Reset asserted mid-transfer SHALL abort immediately; after release TX SHALL stay idle high until a new send_cmd.
REQ-027 send_cmd or RX activity during reset SHALL be ignored.

Verification (BAUD_DIV = 16)
REQ-028 Reset: hold rst_n = 1 for 2 clocks -> TX = 1, cmd_sent = 0, resp_rdy = 0, resp = 8'h00.
REQ-029 Send cmd = 16'h2402 -> TX frames 0x24 then 0x02 LSB first, each bit 16 clocks; cmd_sent rises exactly 320 clocks after TX start bit begins.
REQ-030 Drive RX with an 8N1 frame of 8'hA5 -> resp = 8'hA5, resp_rdy rises at stop-bit mid-point (152 clocks after start edge, plus 2 sync clocks).
REQ-031 Assert send_cmd with cmd = 16'h3F01 at clock 50 of an ongoing 16'h2402 transfer -> second request ignored; TX output identical to REQ-029.
REQ-032 4-clock low pulse on RX while idle -> no byte received; resp and resp_rdy unchanged.
REQ-033 rst_n = 1 during the low byte of a transfer -> TX = 1 next clock, cmd_sent stays 0 after release.

Source files
------------

// File: rtl/remote_comm.sv
// UART link to the robot: sends a 16-bit command as two 8N1 bytes (high byte first)
// and receives single 8N1 response bytes on RX, both directions running independently.
module remote_comm #(
    parameter int BAUD_DIV = 2604
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        RX,
    output logic        TX,
    input  logic [15:0] cmd,
    input  logic        send_cmd,
    output logic        cmd_sent,
    output logic        resp_rdy,
    output logic [7:0]  resp
);

    localparam int CW = $clog2(BAUD_DIV);

    typedef enum logic [1:0] {TX_IDLE, TX_HIGH, TX_LOW} tx_state_t;
    typedef enum logic [1:0] {RX_IDLE, RX_START, RX_DATA, RX_STOP} rx_state_t;

    // ---------------- transmitter ----------------
    tx_state_t   r_tx_state;
    tx_state_t   w_tx_state_next;
    logic [CW-1:0] r_tx_cnt;
    logic [3:0]  r_tx_bit;
    logic [15:0] r_cmd;
    logic        r_cmd_sent;
    logic        w_accept;
    logic        w_tx_bit_end;
    logic        w_tx_frame_end;
    logic [7:0]  w_tx_byte;
    logic [2:0]  w_tx_sel;
    logic        w_tx;

    assign w_accept       = send_cmd && (r_tx_state == TX_IDLE);
    assign w_tx_bit_end   = (r_tx_cnt == CW'(BAUD_DIV - 1));
    assign w_tx_frame_end = w_tx_bit_end && (r_tx_bit == 4'd9);

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_tx_state <= TX_IDLE;
        end else begin
            r_tx_state <= w_tx_state_next;
        end
    end

    always_comb begin
        w_tx_state_next = r_tx_state;
        case (r_tx_state)
            TX_IDLE: if (w_accept)       w_tx_state_next = TX_HIGH;
            TX_HIGH: if (w_tx_frame_end) w_tx_state_next = TX_LOW;
            TX_LOW:  if (w_tx_frame_end) w_tx_state_next = TX_IDLE;
            default:                     w_tx_state_next = TX_IDLE;
        endcase
    end

    // Bit index 0 is the start bit, 1..8 data LSB first, 9 the stop bit.
    always_comb begin
        w_tx_byte = (r_tx_state == TX_HIGH) ? r_cmd[15:8] : r_cmd[7:0];
        w_tx_sel  = 3'(r_tx_bit - 4'd1);
        w_tx      = 1'b1;
        if (r_tx_state != TX_IDLE) begin
            if (r_tx_bit == 4'd0) begin
                w_tx = 1'b0;
            end else if (r_tx_bit != 4'd9) begin
                w_tx = w_tx_byte[w_tx_sel];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_cmd      <= '0;
            r_cmd_sent <= 1'b0;
        end else if (w_accept) begin
            r_cmd      <= cmd;
            r_tx_cnt   <= '0;
            r_tx_bit   <= '0;
            r_cmd_sent <= 1'b0;
        end else if (r_tx_state != TX_IDLE) begin
            if (w_tx_bit_end) begin
                r_tx_cnt <= '0;
                r_tx_bit <= w_tx_frame_end ? 4'd0 : r_tx_bit + 4'd1;
            end else begin
                r_tx_cnt <= r_tx_cnt + CW'(1);
            end
            if ((r_tx_state == TX_LOW) && w_tx_frame_end) begin
                r_cmd_sent <= 1'b1;
            end
        end
    end

    assign TX       = w_tx;
    assign cmd_sent = r_cmd_sent;

    // ---------------- receiver ----------------
    rx_state_t     r_rx_state;
    rx_state_t     w_rx_state_next;
    logic          r_rx_meta;
    logic          r_rx_sync;
    logic          r_rx_prev;
    logic [CW-1:0] r_rx_cnt;
    logic [2:0]    r_rx_bit;
    logic [7:0]    r_rx_shift;
    logic [7:0]    r_resp;
    logic          r_resp_rdy;
    logic          w_rx_fall;
    logic          w_rx_half;
    logic          w_rx_full;
    logic          w_start_ok;
    logic          w_bit_take;
    logic          w_stop_take;

    assign w_rx_fall = r_rx_prev && !r_rx_sync;
    assign w_rx_half = (r_rx_cnt == CW'(BAUD_DIV / 2 - 1));
    assign w_rx_full = (r_rx_cnt == CW'(BAUD_DIV - 1));

    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rx_state <= RX_IDLE;
        end else begin
            r_rx_state <= w_rx_state_next;
        end
    end

    always_comb begin
        w_rx_state_next = r_rx_state;
        case (r_rx_state)
            RX_IDLE:  if (w_rx_fall) w_rx_state_next = RX_START;
            RX_START: if (w_rx_half) w_rx_state_next = r_rx_sync ? RX_IDLE : RX_DATA;
            RX_DATA:  if (w_rx_full && (r_rx_bit == 3'd7)) w_rx_state_next = RX_STOP;
            RX_STOP:  if (w_rx_full) w_rx_state_next = RX_IDLE;
            default:  w_rx_state_next = RX_IDLE;
        endcase
    end

    always_comb begin
        w_start_ok  = (r_rx_state == RX_START) && w_rx_half && !r_rx_sync;
        w_bit_take  = (r_rx_state == RX_DATA)  && w_rx_full;
        w_stop_take = (r_rx_state == RX_STOP)  && w_rx_full;
    end

    // The fall is seen one clock after the synchronized edge, hence the count starts at 1.
    always_ff @(posedge clk) begin
        if (rst_n) begin
            r_rx_meta  <= 1'b1;
            r_rx_sync  <= 1'b1;
            r_rx_prev  <= 1'b1;
            r_rx_cnt   <= '0;
            r_rx_bit   <= '0;
            r_rx_shift <= '0;
            r_resp     <= '0;
            r_resp_rdy <= 1'b0;
        end else begin
            r_rx_meta <= RX;
            r_rx_sync <= r_rx_meta;
            r_rx_prev <= r_rx_sync;
            if (r_rx_state == RX_IDLE) begin
                r_rx_cnt <= w_rx_fall ? CW'(1) : '0;
            end else if (((r_rx_state == RX_START) && w_rx_half) || w_rx_full) begin
                r_rx_cnt <= '0;
            end else begin
                r_rx_cnt <= r_rx_cnt + CW'(1);
            end
            if (w_start_ok) begin
                r_rx_bit <= '0;
            end else if (w_bit_take) begin
                r_rx_bit <= r_rx_bit + 3'd1;
            end
            if (w_bit_take) begin
                r_rx_shift <= {r_rx_sync, r_rx_shift[7:1]};
            end
            if (w_stop_take) begin
                r_resp     <= r_rx_shift;
                r_resp_rdy <= 1'b1;
            end else if (w_start_ok || w_accept) begin
                r_resp_rdy <= 1'b0;
            end
        end
    end

    assign resp     = r_resp;
    assign resp_rdy = r_resp_rdy;

endmodule

// File: tb/tb_remote_comm.sv
// Self-checking bench for remote_comm: random commands and response bytes compared
// against expected 8N1 waveforms built from the framing rules.
module tb_remote_comm;

    localparam int BD     = 16;
    localparam int RX_LAT = 2 + BD / 2 + 9 * BD;  // RX fall to resp_rdy, sync included

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        RX = 1'b1;
    logic        TX;
    logic [15:0] cmd = 16'h0000;
    logic        send_cmd = 1'b0;
    logic        cmd_sent;
    logic        resp_rdy;
    logic [7:0]  resp;

    int n_vec  = 0;
    int n_fail = 0;

    remote_comm #(.BAUD_DIV(BD)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .RX       (RX),
        .TX       (TX),
        .cmd      (cmd),
        .send_cmd (send_cmd),
        .cmd_sent (cmd_sent),
        .resp_rdy (resp_rdy),
        .resp     (resp)
    );

    always #5 clk = ~clk;

    // Drive one 8N1 frame on RX; called just after a rising edge.
    task automatic rx_drive(input logic [7:0] b, input logic stop_bit);
        logic [9:0] f;
        f = {stop_bit, b, 1'b0};
        for (int i = 0; i < 10; i++) begin
            RX = f[i];
            repeat (BD) @(posedge clk);
            #1;
        end
        RX = 1'b1;
    endtask

    // Send c and compare TX with the expected 20-bit stream every clock.
    task automatic do_tx(input logic [15:0] c, input int intrude_at, input logic [15:0] intr);
        logic [19:0] bits;
        bits = {1'b1, c[7:0], 1'b0, 1'b1, c[15:8], 1'b0};
        cmd = c;
        send_cmd = 1'b1;
        @(posedge clk);
        #1;
        send_cmd = 1'b0;
        n_vec++;
        if (cmd_sent !== 1'b0) begin
            n_fail++;
            $display("FAIL tx_sent_clear cmd=%h got=%b want=0", c, cmd_sent);
        end
        for (int i = 0; i < 20 * BD; i++) begin
            send_cmd = (i == intrude_at);
            cmd = (i == intrude_at) ? intr : 16'($urandom);
            n_vec++;
            if (TX !== bits[i / BD]) begin
                n_fail++;
                $display("FAIL tx_bit cmd=%h clk=%0d got=%b want=%b", c, i, TX, bits[i / BD]);
            end
            if (i == 20 * BD - 1) begin
                n_vec++;
                if (cmd_sent !== 1'b0) begin
                    n_fail++;
                    $display("FAIL tx_sent_early cmd=%h got=%b want=0", c, cmd_sent);
                end
            end
            @(posedge clk);
            #1;
        end
        send_cmd = 1'b0;
        n_vec++;
        if (cmd_sent !== 1'b1 || TX !== 1'b1) begin
            n_fail++;
            $display("FAIL tx_done cmd=%h got sent=%b tx=%b want sent=1 tx=1", c, cmd_sent, TX);
        end
        $display("tx cmd=%h intrude_at=%0d done", c, intrude_at);
    endtask

    // Receive one byte and check the exact resp_rdy rise; called just after a rising edge.
    task automatic do_rx(input logic [7:0] b, input logic stop_bit);
        fork
            rx_drive(b, stop_bit);
            begin
                repeat (RX_LAT - 1) @(posedge clk);
                #1;
                n_vec++;
                if (resp_rdy !== 1'b0) begin
                    n_fail++;
                    $display("FAIL rx_rdy_early byte=%h got=%b want=0", b, resp_rdy);
                end
                @(posedge clk);
                #1;
                n_vec++;
                if (resp_rdy !== 1'b1 || resp !== b) begin
                    n_fail++;
                    $display("FAIL rx_byte got rdy=%b resp=%h want rdy=1 resp=%h", resp_rdy, resp, b);
                end
            end
        join
        repeat (2) @(posedge clk);
        #1;
        $display("rx byte=%h stop=%b resp=%h", b, stop_bit, resp);
    endtask

    task automatic test_reset();
        rst_n = 1'b1;
        send_cmd = 1'b1;
        cmd = 16'hFFFF;
        RX = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        n_vec++;
        if (TX !== 1'b1 || cmd_sent !== 1'b0 || resp_rdy !== 1'b0 || resp !== 8'h00) begin
            n_fail++;
            $display("FAIL reset_state got tx=%b sent=%b rdy=%b resp=%h want 1 0 0 00",
                     TX, cmd_sent, resp_rdy, resp);
        end
        send_cmd = 1'b0;
        RX = 1'b1;
        rst_n = 1'b0;
        for (int i = 0; i < 3 * BD; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (TX !== 1'b1 || resp_rdy !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_release clk=%0d got tx=%b rdy=%b want tx=1 rdy=0", i, TX, resp_rdy);
            end
        end
        $display("reset checked");
    endtask

    task automatic test_tx();
        @(posedge clk);
        #1;
        do_tx(16'h2402, -1, 16'h0000);
        for (int k = 0; k < 2; k++) begin
            repeat ($urandom_range(0, 5)) @(posedge clk);
            #1;
            do_tx(16'($urandom), -1, 16'h0000);
        end
    endtask

    task automatic test_busy_ignore();
        @(posedge clk);
        #1;
        do_tx(16'h2402, 50, 16'h3F01);
        do_tx(16'($urandom), 200, 16'($urandom));
    endtask

    task automatic test_rx();
        logic [7:0] b;
        @(posedge clk);
        #1;
        do_rx(8'hA5, 1'b1);
        for (int k = 0; k < 3; k++) begin
            b = 8'($urandom);
            do_rx(b, 1'b1);
        end
        b = 8'($urandom);
        do_rx(b, 1'b0);
        do_rx(8'hA5, 1'b1);
    endtask

    task automatic test_glitch();
        logic [7:0] held;
        held = resp;
        @(posedge clk);
        #1;
        RX = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        RX = 1'b1;
        repeat (3 * BD) @(posedge clk);
        #1;
        n_vec++;
        if (resp_rdy !== 1'b1 || resp !== held) begin
            n_fail++;
            $display("FAIL rx_glitch got rdy=%b resp=%h want rdy=1 resp=%h", resp_rdy, resp, held);
        end
        $display("glitch rejected resp=%h", resp);
    endtask

    task automatic test_send_clears_rdy();
        @(posedge clk);
        #1;
        cmd = 16'($urandom);
        send_cmd = 1'b1;
        @(posedge clk);
        #1;
        send_cmd = 1'b0;
        n_vec++;
        if (resp_rdy !== 1'b0) begin
            n_fail++;
            $display("FAIL rdy_clear_on_send got=%b want=0", resp_rdy);
        end
        repeat (20 * BD + 2) @(posedge clk);
        #1;
        $display("send cleared resp_rdy");
    endtask

    task automatic test_full_duplex();
        for (int k = 0; k < 2; k++) begin
            logic [15:0] c;
            logic [7:0]  b;
            c = 16'($urandom);
            b = 8'($urandom);
            @(posedge clk);
            #1;
            fork
                do_tx(c, -1, 16'h0000);
                do_rx(b, 1'b1);
            join
        end
    endtask

    task automatic test_reset_mid();
        @(posedge clk);
        #1;
        cmd = 16'($urandom);
        send_cmd = 1'b1;
        @(posedge clk);
        #1;
        send_cmd = 1'b0;
        repeat (10 * BD + 5) @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        n_vec++;
        if (TX !== 1'b1 || cmd_sent !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_mid got tx=%b sent=%b want tx=1 sent=0", TX, cmd_sent);
        end
        rst_n = 1'b0;
        for (int i = 0; i < 25 * BD; i++) begin
            @(posedge clk);
            #1;
            n_vec++;
            if (TX !== 1'b1 || cmd_sent !== 1'b0) begin
                n_fail++;
                $display("FAIL reset_mid_after clk=%0d got tx=%b sent=%b want tx=1 sent=0",
                         i, TX, cmd_sent);
            end
        end
        $display("reset mid-transfer checked");
    endtask

    initial begin
        test_reset();
        test_tx();
        test_busy_ignore();
        test_rx();
        test_glitch();
        test_send_clears_rdy();
        test_full_duplex();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule
